// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    BR   = 2'd1,
    JMP  = 2'd2,
    TRAP = 2'd3
  } npc_sel_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_002C;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0004;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: trap > jump > branch > sequential,
// with target alignment masking and misalign detection.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
  parameter int              INST_BYTES = 4
) (
  input  logic [XLEN-1:0] seq_pc,
  input  logic            br_take,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_take,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap,
  output logic [XLEN-1:0] npc,
  output npc_sel_t        npc_sel,
  output logic            npc_misalign
);

  localparam logic [XLEN-1:0] LOW = XLEN'(INST_BYTES - 1);

  always_comb begin
    npc          = seq_pc;
    npc_sel      = SEQ;
    npc_misalign = 1'b0;
    if (trap) begin
      npc     = TRAP_VEC;
      npc_sel = TRAP;
    end else if (jmp_take) begin
      npc          = jmp_target & ~LOW;
      npc_sel      = JMP;
      npc_misalign = |(jmp_target & LOW);
    end else if (br_take) begin
      npc          = br_target & ~LOW;
      npc_sel      = BR;
      npc_misalign = |(br_target & LOW);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter with trap EPC capture and a debug
// run/halt/single-step state machine.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_we,
  input  logic            br_take,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_take,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap,
  input  logic            dbg_halt_req,
  input  logic            dbg_resume,
  input  logic            dbg_step,
  input  logic            dbg_pc_we,
  input  logic [XLEN-1:0] dbg_pc_wdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] epc,
  output logic            halted,
  output logic            misalign
);

  pc_state_t       state;
  pc_state_t       nxt;
  logic [XLEN-1:0] npc;
  npc_sel_t        npc_sel;
  logic            npc_misalign;
  logic            commit;

  assign pc_plus = pc_out + XLEN'(INST_BYTES);
  assign commit  = pc_we && (state != HALTED);

  pc_next_mux #(
    .XLEN       (XLEN),
    .TRAP_VEC   (TRAP_VEC),
    .INST_BYTES (INST_BYTES)
  ) u_mux (
    .seq_pc       (pc_plus),
    .br_take      (br_take),
    .br_target    (br_target),
    .jmp_take     (jmp_take),
    .jmp_target   (jmp_target),
    .trap         (trap),
    .npc          (npc),
    .npc_sel      (npc_sel),
    .npc_misalign (npc_misalign)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      RUN:     if (dbg_halt_req) nxt = HALTED;
      STEP:    if (dbg_halt_req || pc_we) nxt = HALTED;
      HALTED: begin
        if (dbg_resume)    nxt = RUN;
        else if (dbg_step) nxt = STEP;
      end
      default: nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc_out   <= RESET_VEC;
      epc      <= '0;
      halted   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= nxt;
      halted   <= (nxt == HALTED);
      misalign <= commit && npc_misalign;
      if (commit) begin
        pc_out <= npc;
        if (npc_sel == TRAP) epc <= pc_out;
      end else if (state == HALTED && dbg_pc_we) begin
        pc_out <= dbg_pc_wdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: random and directed stimulus
// against a behavioural model of the PC and debug rules.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_we;
  logic        br_take;
  logic [31:0] br_target;
  logic        jmp_take;
  logic [31:0] jmp_target;
  logic        trap;
  logic        dbg_halt_req;
  logic        dbg_resume;
  logic        dbg_step;
  logic        dbg_pc_we;
  logic [31:0] dbg_pc_wdata;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic [31:0] epc;
  logic        halted;
  logic        misalign;

  pc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_we        (pc_we),
    .br_take      (br_take),
    .br_target    (br_target),
    .jmp_take     (jmp_take),
    .jmp_target   (jmp_target),
    .trap         (trap),
    .dbg_halt_req (dbg_halt_req),
    .dbg_resume   (dbg_resume),
    .dbg_step     (dbg_step),
    .dbg_pc_we    (dbg_pc_we),
    .dbg_pc_wdata (dbg_pc_wdata),
    .pc_out       (pc_out),
    .pc_plus      (pc_plus),
    .epc          (epc),
    .halted       (halted),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_halted;
  bit          m_stepping;
  bit          m_mis;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, req, $time);
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_pc = 32'h2C; m_epc = 0; m_halted = 0;
      m_stepping = 0; m_mis = 0;
      return;
    end
    m_mis = 0;
    if (!m_halted) begin
      if (pc_we) begin
        if (trap) begin
          m_epc = m_pc;
          m_pc  = 32'h4;
        end else if (jmp_take) begin
          m_pc  = {jmp_target[31:2], 2'b00};
          m_mis = (jmp_target % 4) != 0;
        end else if (br_take) begin
          m_pc  = {br_target[31:2], 2'b00};
          m_mis = (br_target % 4) != 0;
        end else begin
          m_pc = m_pc + 4;
        end
      end
      if (dbg_halt_req || (m_stepping && pc_we)) begin
        m_halted   = 1;
        m_stepping = 0;
      end
    end else begin
      if (dbg_pc_we) m_pc = dbg_pc_wdata;
      if (dbg_resume) begin
        m_halted = 0;
      end else if (dbg_step) begin
        m_halted   = 0;
        m_stepping = 1;
      end
    end
  endfunction

  task automatic idle();
    rst = 0; pc_we = 0; br_take = 0; jmp_take = 0; trap = 0;
    dbg_halt_req = 0; dbg_resume = 0; dbg_step = 0;
    dbg_pc_we = 0;
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.pc = m_pc; e.epc = m_epc;
    e.halted = m_halted; e.mis = m_mis;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // monitor: one expected record per edge
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("pc_plus", pc_plus, e.pc + 32'd4);
        chk("epc", epc, e.epc);
        chk("halted", {31'd0, halted}, {31'd0, e.halted});
        chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    br_target = 0; jmp_target = 0; dbg_pc_wdata = 0;
    idle();
    @(negedge clk);
    rst = 1; tick();
    idle();
    chk("reset_pc", pc_out, 32'h2C);
    repeat (3) begin pc_we = 1; tick(); end
    chk("seq3", pc_out, 32'h38);
    idle(); repeat (2) tick();
    chk("hold", pc_out, 32'h38);
    pc_we = 1; br_take = 1; jmp_take = 1; trap = 1;
    br_target = 32'h60; jmp_target = 32'h80; tick();
    chk("trap_pc", pc_out, 32'h4);
    chk("trap_epc", epc, 32'h38);
    trap = 0; tick();
    chk("jmp_pc", pc_out, 32'h80);
    idle(); pc_we = 1; jmp_take = 1; jmp_target = 32'h103; tick();
    chk("mis_pc", pc_out, 32'h100);
    chk("mis_hi", {31'd0, misalign}, 32'd1);
    idle(); tick();
    chk("mis_lo", {31'd0, misalign}, 32'd0);
    pc_we = 1; jmp_take = 1; jmp_target = 32'h40; tick();
    idle(); pc_we = 1; dbg_halt_req = 1; tick();
    chk("halt_pc", pc_out, 32'h44);
    chk("halt_hi", {31'd0, halted}, 32'd1);
    idle(); pc_we = 1; repeat (5) tick();
    chk("frozen", pc_out, 32'h44);
    idle(); dbg_pc_we = 1; dbg_pc_wdata = 32'h200; tick();
    chk("dbg_wr", pc_out, 32'h200);
    idle(); pc_we = 1; dbg_step = 1; tick();
    chk("step_lo", {31'd0, halted}, 32'd0);
    dbg_step = 0; tick();
    chk("step_pc", pc_out, 32'h204);
    repeat (2) tick();
    chk("step_once", pc_out, 32'h204);
    dbg_resume = 1; tick();
    dbg_resume = 0; tick();
    chk("resume", pc_out, 32'h208);
    idle(); pc_we = 1; jmp_take = 1; jmp_target = 32'hFFFF_FFFC; tick();
    jmp_take = 0; tick();
    chk("wrap", pc_out, 32'h0);
    idle(); dbg_halt_req = 1; tick();
    idle(); dbg_step = 1; tick();
    idle(); rst = 1; tick();
    idle(); pc_we = 1; tick();
    chk("rst_step", pc_out, 32'h30);
    repeat (3000) begin
      rst          = ($urandom_range(0, 99) == 0);
      pc_we        = ($urandom_range(0, 3) != 0);
      br_take      = ($urandom_range(0, 3) == 0);
      jmp_take     = ($urandom_range(0, 7) == 0);
      trap         = ($urandom_range(0, 15) == 0);
      br_target    = $urandom;
      jmp_target   = $urandom;
      dbg_halt_req = ($urandom_range(0, 31) == 0);
      dbg_resume   = ($urandom_range(0, 7) == 0);
      dbg_step     = ($urandom_range(0, 7) == 0);
      dbg_pc_we    = ($urandom_range(0, 7) == 0);
      dbg_pc_wdata = $urandom;
      tick();
    end
    idle();
    @(negedge clk);
    done = 1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
